// File: rtl/lightbike_pkg.sv
// Shared lightbike definitions: address width, bike orientations, background
// theme colours and the collision detector state encoding.
package lightbike_pkg;

   localparam int unsigned ADDR_W = 19;

   typedef enum logic [2:0] {
      ORIENT_UP    = 3'd0,
      ORIENT_LEFT  = 3'd1,
      ORIENT_DOWN  = 3'd2,
      ORIENT_RIGHT = 3'd3
   } orient_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARM,
      ST_SCAN,
      ST_COMMIT
   } coll_state_t;

   localparam logic [23:0] THEME_DARK_COLOUR  = 24'h000000;
   localparam logic [23:0] THEME_NAVY_COLOUR  = 24'h0C1530;
   localparam logic [23:0] THEME_GREY_COLOUR  = 24'h3A3A3A;
   localparam logic [23:0] THEME_INDIGO_COLOUR = 24'h121428;

   // Themes without a defined colour can never produce a hit.
   function automatic logic theme_hit(input logic [4:0] theme, input logic [23:0] rgb);
      case (theme)
         5'd0, 5'd1: return rgb != THEME_DARK_COLOUR;
         5'd2:       return rgb != THEME_NAVY_COLOUR;
         5'd3:       return rgb != THEME_GREY_COLOUR;
         5'd4:       return rgb != THEME_INDIGO_COLOUR;
         default:    return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/bike_collision_detector_probe_addr_gen.sv
// Combinational probe address generator for one bike: two probes ahead of the
// bike centre. Wall flags are produced only when BIKE_COLL_WALL_HIT_EN is defined.
module probe_addr_gen
   import lightbike_pkg::*;
#(
   parameter int unsigned H_RES       = 640,
   parameter int unsigned V_RES       = 480,
   parameter int unsigned PROBE_AHEAD = 16,
   parameter int unsigned PROBE_SIDE  = 5
) (
   input  logic [ADDR_W-1:0] loc,
   input  logic [2:0]        orient,
   output logic [ADDR_W-1:0] probe_a,
   output logic [ADDR_W-1:0] probe_b,
   output logic              active,
   output logic              wall_a,
   output logic              wall_b
);

   localparam int A = int'(PROBE_AHEAD);
   localparam int S = int'(PROBE_SIDE);
   localparam int W = int'(H_RES);

   int dx_a, dy_a, dx_b, dy_b;

   // Offsets are kept as signed x/y deltas; the linear address wraps modulo 2^19.
   always_comb begin
      active = 1'b1;
      dx_a   = 0;
      dy_a   = 0;
      dx_b   = 0;
      dy_b   = 0;
      case (orient)
         ORIENT_UP:    begin dx_a = -S; dy_a = -A; dx_b =  S; dy_b = -A; end
         ORIENT_LEFT:  begin dx_a = -A; dy_a = -S; dx_b = -A; dy_b =  S; end
         ORIENT_DOWN:  begin dx_a =  S; dy_a =  A; dx_b = -S; dy_b =  A; end
         ORIENT_RIGHT: begin dx_a =  A; dy_a = -S; dx_b =  A; dy_b =  S; end
         default:      active = 1'b0;
      endcase
      probe_a = active ? loc + ADDR_W'(dx_a + dy_a * W) : '0;
      probe_b = active ? loc + ADDR_W'(dx_b + dy_b * W) : '0;
   end

`ifdef BIKE_COLL_WALL_HIT_EN
   int loc_x, loc_y;

   function automatic logic off_frame(input int x, input int y);
      return (x < 0) || (x >= W) || (y < 0) || (y >= int'(V_RES));
   endfunction

   always_comb begin
      loc_x  = int'(loc % ADDR_W'(H_RES));
      loc_y  = int'(loc / ADDR_W'(H_RES));
      wall_a = active && off_frame(loc_x + dx_a, loc_y + dy_a);
      wall_b = active && off_frame(loc_x + dx_b, loc_y + dy_b);
   end
`else
   assign wall_a = 1'b0;
   assign wall_b = 1'b0;
`endif

endmodule

// File: rtl/bike_collision_detector.sv
// Per-frame lightbike collision detector: probes latched at ARM, background pixel
// hits gathered in SCAN, debounce counters updated in COMMIT. Macro: BIKE_COLL_WALL_HIT_EN.
module bike_collision_detector
   import lightbike_pkg::*;
#(
   parameter int unsigned NUM_BIKES   = 2,
   parameter int unsigned H_RES       = 640,
   parameter int unsigned V_RES       = 480,
   parameter int unsigned PROBE_AHEAD = 16,
   parameter int unsigned PROBE_SIDE  = 5,
   parameter int unsigned HIT_FRAMES  = 2
) (
   input  logic                          clock,
   input  logic                          resetn,
   input  logic                          frame_start,
   input  logic                          pixel_valid,
   input  logic [ADDR_W-1:0]             addr,
   input  logic [23:0]                   background_data,
   input  logic [4:0]                    background,
   input  logic [ADDR_W*NUM_BIKES-1:0]   bike_loc,
   input  logic [3*NUM_BIKES-1:0]        bike_orient,
   input  logic                          clear,
   output logic [NUM_BIKES-1:0]          collided,
   output logic                          collision_pulse,
   output logic                          frame_done
);

   coll_state_t state, state_next;

   logic [ADDR_W-1:0]    gen_probe_a [NUM_BIKES];
   logic [ADDR_W-1:0]    gen_probe_b [NUM_BIKES];
   logic [NUM_BIKES-1:0] gen_active, gen_wall_a, gen_wall_b;

   logic [ADDR_W-1:0]    probe_a_q [NUM_BIKES];
   logic [ADDR_W-1:0]    probe_b_q [NUM_BIKES];
   logic [NUM_BIKES-1:0] active_q, hit_q;
   logic [3:0]           cnt_q    [NUM_BIKES];
   logic [3:0]           cnt_next [NUM_BIKES];
   logic [NUM_BIKES-1:0] pixel_hit, coll_next;
   logic                 colour_hit;

   for (genvar g = 0; g < NUM_BIKES; g++) begin : g_probe
      probe_addr_gen #(
         .H_RES       (H_RES),
         .V_RES       (V_RES),
         .PROBE_AHEAD (PROBE_AHEAD),
         .PROBE_SIDE  (PROBE_SIDE)
      ) u_probe (
         .loc     (bike_loc[ADDR_W*g +: ADDR_W]),
         .orient  (bike_orient[3*g +: 3]),
         .probe_a (gen_probe_a[g]),
         .probe_b (gen_probe_b[g]),
         .active  (gen_active[g]),
         .wall_a  (gen_wall_a[g]),
         .wall_b  (gen_wall_b[g])
      );
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:   if (frame_start) state_next = ST_ARM;
         ST_ARM:    state_next = ST_SCAN;
         ST_SCAN:   if (frame_start) state_next = ST_COMMIT;
         ST_COMMIT: state_next = ST_ARM;
         default:   state_next = ST_IDLE;
      endcase
   end

   assign colour_hit = theme_hit(background, background_data);

   always_comb begin
      pixel_hit = '0;
      coll_next = collided;
      for (int unsigned i = 0; i < NUM_BIKES; i++) begin
         pixel_hit[i] = (state == ST_SCAN) && pixel_valid && active_q[i] && colour_hit &&
                        ((addr == probe_a_q[i]) || (addr == probe_b_q[i]));
         if (!active_q[i] || !hit_q[i])
            cnt_next[i] = 4'd0;
         else if (cnt_q[i] == 4'hF)
            cnt_next[i] = 4'hF;
         else
            cnt_next[i] = cnt_q[i] + 4'd1;
         if (cnt_next[i] >= 4'(HIT_FRAMES))
            coll_next[i] = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state           <= ST_IDLE;
         collided        <= '0;
         collision_pulse <= 1'b0;
         frame_done      <= 1'b0;
         active_q        <= '0;
         hit_q           <= '0;
         for (int unsigned i = 0; i < NUM_BIKES; i++) begin
            probe_a_q[i] <= '0;
            probe_b_q[i] <= '0;
            cnt_q[i]     <= '0;
         end
      end else begin
         state           <= state_next;
         frame_done      <= (state == ST_COMMIT);
         collision_pulse <= 1'b0;
         case (state)
            ST_ARM: begin
               active_q <= gen_active;
               hit_q    <= hit_q | (gen_active & (gen_wall_a | gen_wall_b));
               for (int unsigned i = 0; i < NUM_BIKES; i++) begin
                  probe_a_q[i] <= gen_probe_a[i];
                  probe_b_q[i] <= gen_probe_b[i];
               end
            end
            ST_SCAN: hit_q <= hit_q | pixel_hit;
            ST_COMMIT: begin
               collided        <= coll_next;
               collision_pulse <= |(coll_next & ~collided);
               hit_q           <= '0;
               for (int unsigned i = 0; i < NUM_BIKES; i++)
                  cnt_q[i] <= cnt_next[i];
            end
            default: ;
         endcase
         // Clear overrides anything the COMMIT branch scheduled above.
         if (clear) begin
            collided        <= '0;
            collision_pulse <= 1'b0;
            hit_q           <= '0;
            for (int unsigned i = 0; i < NUM_BIKES; i++)
               cnt_q[i] <= '0;
         end
      end
   end

endmodule

// File: doc/bike_collision_detector.md
BIKE_COLLISION_DETECTOR -- requirements
Module: bike_collision_detector

Interface
REQ-001 SHALL have parameter NUM_BIKES, default 2: number of bikes checked per frame.
REQ-002 SHALL have parameter H_RES, default 640: pixels per line.
REQ-003 SHALL have parameter V_RES, default 480: lines per frame.
REQ-004 SHALL have parameter PROBE_AHEAD, default 16: probe distance ahead of bike centre, in pixels.
REQ-005 SHALL have parameter PROBE_SIDE, default 5: probe lateral offset from bike centre, in pixels.
REQ-006 SHALL have parameter HIT_FRAMES, default 2: consecutive hit frames needed to declare a collision (1..15).
REQ-007 SHALL have port clock, input, 1: sole clock, rising edge.
REQ-008 SHALL have port resetn, input, 1: asynchronous, active-low reset.
REQ-009 SHALL have port frame_start, input, 1: single-cycle pulse at least 3 cycles before the first pixel of a frame.
REQ-010 SHALL have port pixel_valid, input, 1: addr and background_data valid this cycle.
REQ-011 SHALL have port addr, input, 19: linear pixel address, y*H_RES+x.
REQ-012 SHALL have port background_data, input, 24: RGB of pixel at addr.
REQ-013 SHALL have port background, input, 5: active background theme.
REQ-014 SHALL have port bike_loc, input, 19*NUM_BIKES: packed centre addresses; bike i is bits [19i+18:19i].
REQ-015 SHALL have port bike_orient, input, 3*NUM_BIKES: packed orientation; 0 up, 1 left, 2 down, 3 right, 4-7 inactive.
REQ-016 SHALL have port clear, input, 1: synchronous clear of flags and counters.
REQ-017 SHALL have port collided, output, NUM_BIKES: sticky per-bike collision flags.
REQ-018 SHALL have port collision_pulse, output, 1: one-cycle pulse when any collided bit rises.
REQ-019 SHALL have port frame_done, output, 1: one-cycle pulse in COMMIT.

Function
REQ-020 SHALL implement states IDLE, ARM, SCAN, COMMIT; IDLE to ARM on frame_start; ARM to SCAN after 1 cycle; SCAN to COMMIT on frame_start; COMMIT to ARM after 1 cycle.
REQ-021 SHALL, in ARM, latch two probe addresses per bike from bike_loc and bike_orient.
REQ-022 SHALL compute probe addresses (A=PROBE_AHEAD, S=PROBE_SIDE, W=H_RES) as: up = loc-S-A*W and loc+S-A*W; left = loc-A-S*W and loc-A+S*W; down = loc+S+A*W and loc-S+A*W; right = loc+A-S*W and loc+A+S*W.
REQ-023 SHALL, in SCAN, set bike i's per-frame hit bit when pixel_valid is high, addr equals either of bike i's latched probes, and background_data is not the theme colour.
REQ-024 SHALL use theme colours: themes 0 and 1 = 000000, 2 = 0C1530, 3 = 3A3A3A, 4 = 121428; themes 5-31 never produce a hit.
REQ-025 SHALL ignore pixel_valid in IDLE, ARM and COMMIT.
REQ-026 SHALL give an inactive orientation (4-7) no probes, with its counter forced to 0.
REQ-027 SHALL, in COMMIT, increment a saturating 4-bit counter for each bike with a hit and zero the counter otherwise.
REQ-028 SHALL set collided[i] when counter i reaches HIT_FRAMES; collided[i] is sticky until clear or reset.
REQ-029 SHALL clear all hit bits in COMMIT.
REQ-030 SHALL register collided, collision_pulse and frame_done; latency from the COMMIT entry edge is 1 cycle.
REQ-031 SHALL have clear zero collided, all counters and all hit bits in any state without changing state; clear wins over a simultaneous COMMIT update.
REQ-032 SHALL treat a frame_start during ARM as a no-op.

Reset
REQ-033 SHALL, on resetn low, asynchronously set state IDLE and set collided, counters, hit bits, probes, collision_pulse and frame_done to 0.
REQ-034 SHALL discard a partial frame when reset is asserted mid-SCAN; the first frame_start after release goes to ARM.

Configuration
REQ-035 SHALL, with BIKE_COLL_WALL_HIT_EN defined, compute probe x,y in ARM and set the hit bit at ARM time for any probe with x outside 0..H_RES-1 or y outside 0..V_RES-1.
REQ-036 SHALL, without BIKE_COLL_WALL_HIT_EN defined, use raw wrapped probe addresses and provide no wall detection.

Structure
REQ-037 SHALL place the orientation enum, the theme colour constants and the 19-bit address width in package lightbike_pkg.
REQ-038 SHALL put the combinational probe arithmetic in sub-module probe_addr_gen, one instance per bike.

Verification
REQ-039 SHALL cover: bike0 loc=64320, up, theme 0; pixel 54075=FFFFFF in two consecutive frames -> collided[0]=1 after 2nd COMMIT, collision_pulse for 1 cycle.
REQ-040 SHALL cover: same hit in frame 1 only, frame 2 clean, frame 3 hit -> collided[0] stays 0.
REQ-041 SHALL cover: theme 3, probe pixel=3A3A3A -> no hit; probe pixel=3A3A3B -> hit bit set.
REQ-042 SHALL cover: clear asserted in the COMMIT cycle that would set collided -> collided=0, counters=0.
REQ-043 SHALL cover: with BIKE_COLL_WALL_HIT_EN, loc=5*640+320, up -> collided[0]=1 after 2 frames with all-background pixels.
REQ-044 SHALL cover: resetn low mid-SCAN with a hit pending -> all outputs 0; next frame_start enters ARM.
